// File: rtl/spi_frame_slave_if.sv
// ----------------------------------------------------------------------------
// spi_frame_slave_if
//
// Bundles the SPI pins and the frame-side bus of spi_frame_slave.
//   SPI_SCK, SPI_SSEL, SPI_MOSI : SPI pins driven by the external master
//                                 (SSEL active low)
//   SPI_MISO                    : serial reply, MSB first
//   tx_data                     : reply frame, captured at frame start
//   rx_data                     : last accepted frame
//   rx_valid / frame_err        : one-cycle accept / reject strobes
//   err_code                    : bit0 length error, bit1 header error
//   busy                        : frame in progress
//   good_count / err_count      : accepted / rejected frame counters
//
// Modport slave is the engine's view; modport master is the host/bench view.
// ----------------------------------------------------------------------------
interface spi_frame_slave_if #(
    parameter int FRAME_BITS = 64
);
    logic                  SPI_SCK;
    logic                  SPI_SSEL;
    logic                  SPI_MOSI;
    logic                  SPI_MISO;
    logic [FRAME_BITS-1:0] tx_data;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  rx_valid;
    logic                  frame_err;
    logic [1:0]            err_code;
    logic                  busy;
    logic [15:0]           good_count;
    logic [15:0]           err_count;

    modport slave (
        input  SPI_SCK, SPI_SSEL, SPI_MOSI, tx_data,
        output SPI_MISO, rx_data, rx_valid, frame_err, err_code, busy,
               good_count, err_count
    );

    modport master (
        output SPI_SCK, SPI_SSEL, SPI_MOSI, tx_data,
        input  SPI_MISO, rx_data, rx_valid, frame_err, err_code, busy,
               good_count, err_count
    );
endinterface

// File: rtl/spi_frame_slave.sv
// ----------------------------------------------------------------------------
// spi_frame_slave
//
// SPI slave frame engine for the host link. Supports all four SPI modes,
// a configurable frame length and an optional header check on the received
// MSBs. Accepted frames are published on rx_data with an rx_valid strobe,
// rejected frames raise frame_err with a reason in err_code. Good frames are
// counted with a wrapping counter, rejected frames with a saturating one.
//
// Ports:
//   clk   : system clock, all logic on the rising edge
//   reset : synchronous, active-high
//   bus   : spi_frame_slave_if.slave (SPI pins + frame-side outputs)
//
// Parameters:
//   FRAME_BITS  : frame length in bits (>= 8)
//   CPOL        : idle SCK level
//   CPHA        : 0 = sample on leading edge, 1 = sample on trailing edge
//   HEADER_BITS : width of header check on rx MSBs, 0 disables it
//   HEADER      : required header value (low HEADER_BITS bits are used)
// ----------------------------------------------------------------------------
module spi_frame_slave #(
    parameter int                    FRAME_BITS  = 64,
    parameter int                    CPOL        = 0,
    parameter int                    CPHA        = 0,
    parameter int                    HEADER_BITS = 32,
    parameter logic [FRAME_BITS-1:0] HEADER      = FRAME_BITS'(32'h74697277)
) (
    input  logic                clk,
    input  logic                reset,
    spi_frame_slave_if.slave    bus
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    // Slice width used for the header compare; kept >= 1 so the slice is legal
    // even when the check is disabled.
    localparam int HB = (HEADER_BITS > 0) ? HEADER_BITS : 1;
    localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        CHECK
    } state_t;

    // ------------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------------
    logic [2:0] sck_s;
    logic [2:0] ssel_s;
    logic [2:0] mosi_s;
    logic [1:0] arm_wait;
    logic       armed;

    // The SSEL synchroniser resets to idle, so a pin held low across reset
    // would otherwise look like a fresh falling edge. Frame starts are only
    // honoured once SSEL has been seen high with every synchroniser stage
    // holding a real pin sample (arm_wait flushes the reset values).
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s    <= '0;
            mosi_s   <= '0;
            ssel_s   <= '1;
            arm_wait <= 2'd3;
            armed    <= 1'b0;
        end else begin
            sck_s  <= {sck_s[1:0], bus.SPI_SCK};
            ssel_s <= {ssel_s[1:0], bus.SPI_SSEL};
            mosi_s <= {mosi_s[1:0], bus.SPI_MOSI};
            if (arm_wait != 2'd0) begin
                arm_wait <= arm_wait - 2'd1;
            end else if (ssel_s[2:1] == 2'b11) begin
                armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Edge detection and frame checks
    // ------------------------------------------------------------------------
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  sample_edge;
    logic                  shift_edge;
    logic                  ssel_fall;
    logic                  ssel_rise;
    logic                  mosi_bit;
    logic                  len_err;
    logic                  hdr_err;
    logic                  hold_first;

    state_t                state;
    logic [FRAME_BITS-1:0] rx_shreg;
    logic [FRAME_BITS-1:0] tx_shreg;
    logic [FRAME_BITS-1:0] rx_data_q;
    logic [CNT_W-1:0]      bitcnt;
    logic                  rx_valid_q;
    logic                  frame_err_q;
    logic [1:0]            err_code_q;
    logic                  busy_q;
    logic                  miso_q;
    logic [15:0]           good_cnt;
    logic [15:0]           err_cnt;

    always_comb begin
        sck_rise    = (sck_s[2:1] == 2'b01);
        sck_fall    = (sck_s[2:1] == 2'b10);
        ssel_fall   = (ssel_s[2:1] == 2'b10);
        ssel_rise   = (ssel_s[2:1] == 2'b01);
        sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
        shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;
        mosi_bit    = mosi_s[2];
        // With CPHA=1 the first leading edge is a shift edge that arrives
        // before any sample; skipping it keeps the MSB on MISO for bit 0.
        hold_first  = (CPHA != 0) && (bitcnt == '0);
        len_err     = (bitcnt != CNT_FULL);
        hdr_err     = (HEADER_BITS > 0) &&
                      (rx_shreg[FRAME_BITS-1 -: HB] != HEADER[HB-1:0]);
    end

    // ------------------------------------------------------------------------
    // Frame state machine with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rx_shreg    <= '0;
            tx_shreg    <= '0;
            bitcnt      <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
            good_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= (state == ACTIVE) ? tx_shreg[FRAME_BITS-1] : 1'b0;

            case (state)
                IDLE: begin
                    if (ssel_fall && armed) begin
                        state    <= ACTIVE;
                        tx_shreg <= bus.tx_data;
                        bitcnt   <= '0;
                        busy_q   <= 1'b1;
                    end
                end

                ACTIVE: begin
                    if (sample_edge) begin
                        rx_shreg <= {rx_shreg[FRAME_BITS-2:0], mosi_bit};
                        if (bitcnt != CNT_SAT) begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                    if (shift_edge && !hold_first) begin
                        tx_shreg <= {tx_shreg[FRAME_BITS-2:0], 1'b0};
                    end
                    if (ssel_rise) begin
                        state  <= CHECK;
                        busy_q <= 1'b0;
                    end
                end

                CHECK: begin
                    state <= IDLE;
                    if (len_err || hdr_err) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= {hdr_err, len_err};
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 16'd1;
                        end
                    end else begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_shreg;
                        good_cnt   <= good_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.SPI_MISO   = miso_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_code   = err_code_q;
    assign bus.busy       = busy_q;
    assign bus.good_count = good_cnt;
    assign bus.err_count  = err_cnt;

endmodule

// File: tb/tb_spi_frame_slave.sv
// ----------------------------------------------------------------------------
// tb_spi_frame_slave
//
// Five engines: u0..u3 cover (CPOL,CPHA) = (0,0),(0,1),(1,0),(1,1) with the
// default header; u4 has the header check disabled. A directed driver pushes
// the expected outcome of each frame into a per-engine queue; a monitor pops
// and compares whenever an engine strobes rx_valid or frame_err.
// ----------------------------------------------------------------------------
module tb_spi_frame_slave;

    localparam int HALF = 8;
    localparam bit [4:0] CPOL_V = 5'b01100;
    localparam bit [4:0] CPHA_V = 5'b01010;
    localparam logic [63:0] GOOD_A = 64'h74697277_DEADBEEF;
    localparam logic [63:0] GOOD_B = 64'h74697277_12345678;
    localparam logic [63:0] TX_A   = 64'h01234567_89ABCDEF;
    localparam logic [63:0] TX_B   = 64'hFEDCBA98_76543210;

    typedef struct packed {
        logic        err;
        logic [1:0]  code;
        logic [63:0] data;
        logic [15:0] gc;
        logic [15:0] ec;
        logic        chk_miso;
        logic [63:0] miso;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  sck_v;
    logic [4:0]  ssel_v = 5'b11111;
    logic        mosi = 1'b0;
    logic [63:0] tx_d = '0;
    logic [4:0]  miso_v;
    logic [4:0]  busy_v;

    logic [63:0] miso_cap [5];
    logic [4:0]  first_bit;
    logic [63:0] m_rx [5];
    logic [15:0] m_gc [5];
    logic [15:0] m_ec [5];
    logic [1:0]  m_code [5];
    exp_t        sbq [5][$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_frame_slave_if #(.FRAME_BITS(64)) if0 ();
    spi_frame_slave_if #(.FRAME_BITS(64)) if1 ();
    spi_frame_slave_if #(.FRAME_BITS(64)) if2 ();
    spi_frame_slave_if #(.FRAME_BITS(64)) if3 ();
    spi_frame_slave_if #(.FRAME_BITS(64)) if4 ();

    assign if0.SPI_SCK = sck_v[0];  assign if0.SPI_SSEL = ssel_v[0];
    assign if1.SPI_SCK = sck_v[1];  assign if1.SPI_SSEL = ssel_v[1];
    assign if2.SPI_SCK = sck_v[2];  assign if2.SPI_SSEL = ssel_v[2];
    assign if3.SPI_SCK = sck_v[3];  assign if3.SPI_SSEL = ssel_v[3];
    assign if4.SPI_SCK = sck_v[4];  assign if4.SPI_SSEL = ssel_v[4];
    assign if0.SPI_MOSI = mosi;  assign if0.tx_data = tx_d;
    assign if1.SPI_MOSI = mosi;  assign if1.tx_data = tx_d;
    assign if2.SPI_MOSI = mosi;  assign if2.tx_data = tx_d;
    assign if3.SPI_MOSI = mosi;  assign if3.tx_data = tx_d;
    assign if4.SPI_MOSI = mosi;  assign if4.tx_data = tx_d;
    assign miso_v[0] = if0.SPI_MISO;  assign busy_v[0] = if0.busy;
    assign miso_v[1] = if1.SPI_MISO;  assign busy_v[1] = if1.busy;
    assign miso_v[2] = if2.SPI_MISO;  assign busy_v[2] = if2.busy;
    assign miso_v[3] = if3.SPI_MISO;  assign busy_v[3] = if3.busy;
    assign miso_v[4] = if4.SPI_MISO;  assign busy_v[4] = if4.busy;

    spi_frame_slave #(.FRAME_BITS(64), .CPOL(0), .CPHA(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    spi_frame_slave #(.FRAME_BITS(64), .CPOL(0), .CPHA(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    spi_frame_slave #(.FRAME_BITS(64), .CPOL(1), .CPHA(0)) u2 (.clk(clk), .reset(reset), .bus(if2));
    spi_frame_slave #(.FRAME_BITS(64), .CPOL(1), .CPHA(1)) u3 (.clk(clk), .reset(reset), .bus(if3));
    spi_frame_slave #(.FRAME_BITS(64), .CPOL(0), .CPHA(0), .HEADER_BITS(0)) u4 (.clk(clk), .reset(reset), .bus(if4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_rx[k] = '0; m_gc[k] = '0; m_ec[k] = '0; m_code[k] = '0;
        end
    endtask

    // Master reads MISO just before its sample edge.
    task automatic capture(input int k, input int idx);
        if (idx < 64) miso_cap[k] = {miso_cap[k][62:0], miso_v[k]};
        if (idx == 0) first_bit[k] = miso_v[k];
    endtask

    task automatic xfer_bit(input int k, input logic b, input int idx);
        if (CPHA_V[k] == 1'b0) begin
            mosi = b;
            wait_clk(HALF);
            capture(k, idx);
            sck_v[k] = ~CPOL_V[k];
            wait_clk(HALF);
            sck_v[k] = CPOL_V[k];
        end else begin
            sck_v[k] = ~CPOL_V[k];
            mosi = b;
            wait_clk(HALF);
            capture(k, idx);
            sck_v[k] = CPOL_V[k];
            wait_clk(HALF);
        end
    endtask

    task automatic frame_end(input int k);
        wait_clk(HALF);
        ssel_v[k] = 1'b1;
        wait_clk(16);
    endtask

    task automatic send(input int k, input logic [127:0] data, input int n,
                        input logic [63:0] tx, input logic exp_err,
                        input logic [1:0] code, input logic chk_miso);
        exp_t e;
        if (exp_err) begin
            m_code[k] = code;
            if (m_ec[k] != 16'hFFFF) m_ec[k] = m_ec[k] + 16'd1;
        end else begin
            m_rx[k] = data[63:0];
            m_gc[k] = m_gc[k] + 16'd1;
        end
        e.err = exp_err; e.code = m_code[k]; e.data = m_rx[k];
        e.gc = m_gc[k]; e.ec = m_ec[k]; e.chk_miso = chk_miso; e.miso = tx;
        sbq[k].push_back(e);
        tx_d = tx;
        miso_cap[k] = '0;
        ssel_v[k] = 1'b0;
        wait_clk(6);
        chk($sformatf("u%0d_busy_high", k), 64'(busy_v[k]), 64'd1);
        for (int i = 0; i < n; i++) xfer_bit(k, data[n-1-i], i);
        frame_end(k);
        chk($sformatf("u%0d_busy_low", k), 64'(busy_v[k]), 64'd0);
    endtask

    task automatic mon(input int k, input logic v, input logic fe, input logic [63:0] d,
                       input logic [1:0] c, input logic [15:0] gc, input logic [15:0] ec);
        exp_t e;
        if (v || fe) begin
            if (sbq[k].size() == 0) begin
                total++;
                bad++;
                $display("FAIL u%0d_unexpected: rx_valid=%b frame_err=%b expected no pulse", k, v, fe);
            end else begin
                e = sbq[k].pop_front();
                chk($sformatf("u%0d_rx_valid", k), 64'(v), 64'(!e.err));
                chk($sformatf("u%0d_frame_err", k), 64'(fe), 64'(e.err));
                chk($sformatf("u%0d_rx_data", k), d, e.data);
                chk($sformatf("u%0d_err_code", k), 64'(c), 64'(e.code));
                chk($sformatf("u%0d_good_count", k), 64'(gc), 64'(e.gc));
                chk($sformatf("u%0d_err_count", k), 64'(ec), 64'(e.ec));
                if (e.chk_miso) chk($sformatf("u%0d_miso_stream", k), miso_cap[k], e.miso);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, if0.rx_valid, if0.frame_err, if0.rx_data, if0.err_code, if0.good_count, if0.err_count);
        mon(1, if1.rx_valid, if1.frame_err, if1.rx_data, if1.err_code, if1.good_count, if1.err_count);
        mon(2, if2.rx_valid, if2.frame_err, if2.rx_data, if2.err_code, if2.good_count, if2.err_count);
        mon(3, if3.rx_valid, if3.frame_err, if3.rx_data, if3.err_code, if3.good_count, if3.err_count);
        mon(4, if4.rx_valid, if4.frame_err, if4.rx_data, if4.err_code, if4.good_count, if4.err_count);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] part;
        sck_v = CPOL_V;
        model_reset();
        wait_clk(4);
        reset = 1'b0;
        wait_clk(8);

        // Reset state
        chk("rst_rx_data", if0.rx_data, 64'd0);
        chk("rst_rx_valid", 64'(if0.rx_valid), 64'd0);
        chk("rst_frame_err", 64'(if0.frame_err), 64'd0);
        chk("rst_err_code", 64'(if0.err_code), 64'd0);
        chk("rst_busy", 64'(if0.busy), 64'd0);
        chk("rst_good_count", 64'(if0.good_count), 64'd0);
        chk("rst_err_count", 64'(if0.err_count), 64'd0);
        chk("rst_miso", 64'(if0.SPI_MISO), 64'd0);

        // Good frame in all four modes
        send(0, 128'(GOOD_A), 64, TX_A, 1'b0, 2'b00, 1'b1);
        send(1, 128'(GOOD_A), 64, TX_A, 1'b0, 2'b00, 1'b1);
        chk("u1_first_miso", 64'(first_bit[1]), 64'(TX_A[63]));
        send(2, 128'(GOOD_A), 64, TX_A, 1'b0, 2'b00, 1'b1);
        send(3, 128'(GOOD_A), 64, TX_B, 1'b0, 2'b00, 1'b1);
        chk("u3_first_miso", 64'(first_bit[3]), 64'(TX_B[63]));

        // Header check disabled: arbitrary frame accepted, short frame rejected
        send(4, 128'(64'h00001111_22223333), 64, TX_B, 1'b0, 2'b00, 1'b1);
        send(4, 128'(64'h44445555_66667777), 63, TX_A, 1'b1, 2'b01, 1'b0);

        // Second good frame ending in 0 so the following 63-bit frame lands a
        // valid header in rx_shreg and reports only a length error.
        send(0, 128'(GOOD_B), 64, TX_B, 1'b0, 2'b00, 1'b1);
        send(0, 128'(64'h74697277_CAFEF00D), 63, TX_A, 1'b1, 2'b01, 1'b0);
        // Long frame: last 64 bits carry a valid header
        send(0, {58'd0, 6'h2A, GOOD_A}, 70, TX_A, 1'b1, 2'b01, 1'b0);
        // Bad header
        send(0, 128'(64'h74697278_DEADBEEF), 64, TX_A, 1'b1, 2'b10, 1'b0);

        // Reset mid-frame with SSEL held low: no pulse expected
        part = GOOD_A;
        tx_d = TX_A;
        ssel_v[0] = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 20; i++) xfer_bit(0, part[63-i], i);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        model_reset();
        for (int i = 20; i < 64; i++) xfer_bit(0, part[63-i], i);
        frame_end(0);
        chk("midrst_good_count", 64'(if0.good_count), 64'd0);
        chk("midrst_err_count", 64'(if0.err_count), 64'd0);
        send(0, 128'(GOOD_B), 64, TX_A, 1'b0, 2'b00, 1'b1);

        // Counter boundaries
        force u0.good_cnt = 16'hFFFF;
        wait_clk(2);
        release u0.good_cnt;
        wait_clk(2);
        chk("preload_good_count", 64'(if0.good_count), 64'hFFFF);
        m_gc[0] = 16'hFFFF;
        send(0, 128'(GOOD_A), 64, TX_B, 1'b0, 2'b00, 1'b1);

        force u0.err_cnt = 16'hFFFF;
        wait_clk(2);
        release u0.err_cnt;
        wait_clk(2);
        chk("preload_err_count", 64'(if0.err_count), 64'hFFFF);
        m_ec[0] = 16'hFFFF;
        send(0, 128'(64'h74697278_DEADBEEF), 64, TX_A, 1'b1, 2'b10, 1'b0);

        wait_clk(20);
        for (int k = 0; k < 5; k++)
            chk($sformatf("u%0d_pending_outputs", k), 64'(sbq[k].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
